// File: rtl/sdram_bist_pkg.sv
// Shared definitions for the SDRAM BIST controller: FSM state encoding,
// pattern mode codes, index width and the error counter ceiling.
package sdram_bist_pkg;

    localparam int IDX_W = 10;
    localparam int ERR_W = 16;

    // Error counter sticks here instead of wrapping back to zero
    localparam logic [ERR_W-1:0] ERR_CNT_MAX = 16'hFFFF;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_WAIT_INIT,
        ST_LOAD_WR,
        ST_WRITE,
        ST_LOAD_RD,
        ST_FILL,
        ST_READ,
        ST_DRAIN,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        MODE_INDEX = 2'd0,   // index, zero-extended
        MODE_INV   = 2'd1,   // bitwise inverse of the zero-extended index
        MODE_WALK  = 2'd2,   // walking one driven by index[3:0]
        MODE_SEED  = 2'd3    // seed XOR index
    } mode_t;

endpackage

// File: rtl/sdram_bist_patgen.sv
// Pure combinational test-pattern generator. The controller uses one copy
// to produce write data and a second copy to rebuild the expected read data.
module sdram_bist_patgen
    import sdram_bist_pkg::*;
#(
    parameter int DATA_W = 16
)(
    input  mode_t             mode,
    input  logic [DATA_W-1:0] seed,
    input  logic [IDX_W-1:0]  index,
    output logic [DATA_W-1:0] pattern
);

    // Select the data word for this index under the chosen pattern mode
    always_comb begin
        // NOTE: default first so every path drives pattern and no latch is inferred.
        pattern = '0;
        unique case (mode)
            MODE_INDEX: pattern = DATA_W'(index);
            MODE_INV:   pattern = ~DATA_W'(index);
            MODE_WALK:  pattern = DATA_W'(1) << index[3:0];
            MODE_SEED:  pattern = seed ^ DATA_W'(index);
            default:    pattern = '0;
        endcase
    end

endmodule

// File: rtl/sdram_bist_ctrl.sv
// SDRAM built-in self-test controller. Writes a generated pattern through
// the SDRAM write FIFO, reloads the read address, waits for the read FIFO
// to fill, reads the same number of words back and counts mismatches.
// A loss of sdram_init_done during the active phases aborts the run.
module sdram_bist_ctrl
    import sdram_bist_pkg::*;
#(
    parameter int DATA_W    = 16,
    parameter int LOAD_CYC  = 4,
    parameter int FILL_WAIT = 64,
    parameter int RD_LAT    = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [9:0]        length,
    input  logic [1:0]        mode,
    input  logic [DATA_W-1:0] seed,
    input  logic              sdram_init_done,
    output logic              wr_load,
    output logic              rd_load,
    output logic              sys_we,
    output logic [DATA_W-1:0] sys_data_in,
    output logic              sys_rd,
    input  logic [DATA_W-1:0] sys_data_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              init_lost,
    output logic [15:0]       err_cnt,
    output logic [9:0]        first_err_idx
);

    localparam int WAIT_W = 16;
    localparam logic [WAIT_W-1:0] LOAD_LAST  = WAIT_W'(LOAD_CYC - 1);
    localparam logic [WAIT_W-1:0] FILL_LAST  = WAIT_W'(FILL_WAIT - 1);
    localparam logic [WAIT_W-1:0] DRAIN_LAST = WAIT_W'(RD_LAT - 1);

    state_t             state;
    logic [IDX_W-1:0]   len_q;
    mode_t              mode_q;
    logic [DATA_W-1:0]  seed_q;
    logic [IDX_W-1:0]   idx;        // next word index to issue
    logic [IDX_W-1:0]   rd_idx;     // index of the word currently requested by sys_rd
    logic [WAIT_W-1:0]  wait_cnt;

    logic [RD_LAT-1:0]  cmp_vld;
    logic [IDX_W-1:0]   cmp_idx [RD_LAT];

    logic [DATA_W-1:0]  wr_pat;
    logic [DATA_W-1:0]  cmp_pat;
    logic               cmp_en;
    logic               mismatch;
    logic               abort_win;

    sdram_bist_patgen #(.DATA_W(DATA_W)) u_patgen_wr (
        .mode    (mode_q),
        .seed    (seed_q),
        .index   (idx),
        .pattern (wr_pat)
    );

    sdram_bist_patgen #(.DATA_W(DATA_W)) u_patgen_cmp (
        .mode    (mode_q),
        .seed    (seed_q),
        .index   (cmp_idx[RD_LAT-1]),
        .pattern (cmp_pat)
    );

    // A word returned by the read FIFO is only judged while the run is in its read phases
    assign cmp_en    = cmp_vld[RD_LAT-1] && (state == ST_READ || state == ST_DRAIN);
    assign mismatch  = cmp_en && (sys_data_out != cmp_pat);
    assign abort_win = (state inside {ST_LOAD_WR, ST_WRITE, ST_LOAD_RD,
                                      ST_FILL, ST_READ, ST_DRAIN});

    // Delay the read strobe so it lines up with the data returned RD_LAT cycles later
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmp_vld <= '0;
        end else begin
            cmp_vld[0] <= sys_rd;
            for (int i = 1; i < RD_LAT; i++) begin
                cmp_vld[i] <= cmp_vld[i-1];
            end
        end
    end

    // Carry each read index alongside its strobe
    // NOTE: no reset here; stale indices are harmless because cmp_vld gates every use.
    always_ff @(posedge clk) begin
        cmp_idx[0] <= rd_idx;
        for (int i = 1; i < RD_LAT; i++) begin
            cmp_idx[i] <= cmp_idx[i-1];
        end
    end

    // Run sequencing, FIFO strobes and result bookkeeping
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            wr_load       <= 1'b1;
            rd_load       <= 1'b1;
            sys_we        <= 1'b0;
            sys_rd        <= 1'b0;
            sys_data_in   <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            init_lost     <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= '0;
            len_q         <= '0;
            mode_q        <= MODE_INDEX;
            seed_q        <= '0;
            idx           <= '0;
            rd_idx        <= '0;
            wait_cnt      <= '0;
        end else begin
            // NOTE: non-blocking throughout so every update reads pre-edge values.
            done <= 1'b0;

            if (mismatch) begin
                if (err_cnt != ERR_CNT_MAX) begin
                    err_cnt <= err_cnt + 16'd1;
                end
                if (err_cnt == '0) begin
                    first_err_idx <= cmp_idx[RD_LAT-1];
                end
            end

            if (abort_win && !sdram_init_done) begin
                // SDRAM fell out of init: stop all traffic and report the loss
                sys_we    <= 1'b0;
                sys_rd    <= 1'b0;
                wr_load   <= 1'b0;
                rd_load   <= 1'b0;
                init_lost <= 1'b1;
                state     <= ST_FINISH;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            len_q         <= length;
                            mode_q        <= mode_t'(mode);
                            seed_q        <= seed;
                            err_cnt       <= '0;
                            first_err_idx <= '0;
                            init_lost     <= 1'b0;
                            idx           <= '0;
                            busy          <= 1'b1;
                            state         <= ST_WAIT_INIT;
                        end
                    end

                    ST_WAIT_INIT: begin
                        if (sdram_init_done) begin
                            rd_load  <= 1'b0;
                            wait_cnt <= '0;
                            state    <= ST_LOAD_WR;
                        end
                    end

                    ST_LOAD_WR: begin
                        if (wait_cnt == LOAD_LAST) begin
                            wr_load  <= 1'b0;
                            wait_cnt <= '0;
                            if (len_q != '0) begin
                                sys_we      <= 1'b1;
                                sys_data_in <= wr_pat;
                                idx         <= idx + 1'b1;
                                state       <= ST_WRITE;
                            end else begin
                                rd_load <= 1'b1;
                                state   <= ST_LOAD_RD;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    ST_WRITE: begin
                        if (idx == len_q) begin
                            sys_we   <= 1'b0;
                            idx      <= '0;
                            rd_load  <= 1'b1;
                            wait_cnt <= '0;
                            state    <= ST_LOAD_RD;
                        end else begin
                            sys_data_in <= wr_pat;
                            idx         <= idx + 1'b1;
                        end
                    end

                    ST_LOAD_RD: begin
                        if (wait_cnt == LOAD_LAST) begin
                            rd_load  <= 1'b0;
                            wait_cnt <= '0;
                            state    <= ST_FILL;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    ST_FILL: begin
                        if (wait_cnt == FILL_LAST) begin
                            wait_cnt <= '0;
                            if (len_q != '0) begin
                                sys_rd <= 1'b1;
                                rd_idx <= '0;
                                idx    <= idx + 1'b1;
                                state  <= ST_READ;
                            end else begin
                                state <= ST_DRAIN;
                            end
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    ST_READ: begin
                        if (idx == len_q) begin
                            sys_rd   <= 1'b0;
                            idx      <= '0;
                            wait_cnt <= '0;
                            state    <= ST_DRAIN;
                        end else begin
                            rd_idx <= idx;
                            idx    <= idx + 1'b1;
                        end
                    end

                    ST_DRAIN: begin
                        if (wait_cnt == DRAIN_LAST) begin
                            state <= ST_FINISH;
                        end else begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end

                    ST_FINISH: begin
                        done    <= 1'b1;
                        pass    <= (err_cnt == '0) && !init_lost;
                        busy    <= 1'b0;
                        wr_load <= 1'b1;
                        rd_load <= 1'b1;
                        state   <= ST_IDLE;
                    end

                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sdram_bist_ctrl.sv
// Self-checking bench for sdram_bist_ctrl with an ideal write/read FIFO
// model (one-cycle read latency) that can corrupt selected read words.
`timescale 1ns/1ps
module tb_sdram_bist_ctrl;

    localparam int DATA_W    = 16;
    localparam int LOAD_CYC  = 4;
    localparam int FILL_WAIT = 64;
    localparam int RD_LAT    = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [9:0]  length;
    logic [1:0]  mode;
    logic [15:0] seed;
    logic        sdram_init_done;
    logic        wr_load, rd_load, sys_we, sys_rd;
    logic [15:0] sys_data_in;
    logic [15:0] sys_data_out = '0;
    logic        busy, done, pass, init_lost;
    logic [15:0] err_cnt;
    logic [9:0]  first_err_idx;

    int n_tests = 0;
    int n_fail  = 0;

    // FIFO / SDRAM model state
    logic [15:0] mem [1024];
    logic [9:0]  wp, rp;
    bit          corrupt [1024];

    // Monitor records
    logic [15:0] wr_log [$];
    int rd_beats   = 0;
    int done_cnt   = 0;
    int rdload_cyc = 0;

    int base_we, base_rd, base_done;
    int seen;
    bit got;

    sdram_bist_ctrl #(
        .DATA_W    (DATA_W),
        .LOAD_CYC  (LOAD_CYC),
        .FILL_WAIT (FILL_WAIT),
        .RD_LAT    (RD_LAT)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .start           (start),
        .length          (length),
        .mode            (mode),
        .seed            (seed),
        .sdram_init_done (sdram_init_done),
        .wr_load         (wr_load),
        .rd_load         (rd_load),
        .sys_we          (sys_we),
        .sys_data_in     (sys_data_in),
        .sys_rd          (sys_rd),
        .sys_data_out    (sys_data_out),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .init_lost       (init_lost),
        .err_cnt         (err_cnt),
        .first_err_idx   (first_err_idx)
    );

    always #5 clk = ~clk;

    // Ideal FIFO: load pulses rewind pointers, read data appears one cycle after sys_rd
    always @(posedge clk) begin
        if (wr_load) begin
            wp <= '0;
        end else if (sys_we) begin
            mem[wp] <= sys_data_in;
            wp      <= wp + 10'd1;
        end
        if (rd_load) begin
            rp <= '0;
        end else if (sys_rd) begin
            sys_data_out <= mem[rp] ^ (corrupt[rp] ? 16'h5A5A : 16'h0000);
            rp           <= rp + 10'd1;
        end
    end

    // Passive observation of the DUT strobes, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
            if (sys_we) wr_log.push_back(sys_data_in);
            if (sys_rd) rd_beats++;
            if (done) done_cnt++;
            if (busy && rd_load && !wr_load) rdload_cyc++;
        end
    end

    // Expected data word, computed arithmetically from the pattern rules
    function automatic logic [15:0] exp_pat(input int md, input logic [15:0] sd, input int i);
        case (md)
            0:       return 16'(i);
            1:       return 16'(65535 - i);
            2:       return 16'(2 ** (i % 16));
            default: return sd ^ 16'(i);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " wr_load"},       32'(wr_load),       1);
        check({tag, " rd_load"},       32'(rd_load),       1);
        check({tag, " sys_we"},        32'(sys_we),        0);
        check({tag, " sys_rd"},        32'(sys_rd),        0);
        check({tag, " sys_data_in"},   32'(sys_data_in),   0);
        check({tag, " busy"},          32'(busy),          0);
        check({tag, " done"},          32'(done),          0);
        check({tag, " pass"},          32'(pass),          0);
        check({tag, " init_lost"},     32'(init_lost),     0);
        check({tag, " err_cnt"},       32'(err_cnt),       0);
        check({tag, " first_err_idx"}, 32'(first_err_idx), 0);
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic clear_corrupt();
        for (int i = 0; i < 1024; i++) corrupt[i] = 1'b0;
    endtask

    // One complete run with full scoreboard checks against the reference rules
    task automatic run_test(input string name, input int len, input int md, input logic [15:0] sd);
        int b_we, b_rd, b_done, b_rl, n_we, exp_err, exp_first;
        bit ok;
        check({name, " idle before start"}, 32'(busy), 0);
        b_we   = wr_log.size();
        b_rd   = rd_beats;
        b_done = done_cnt;
        b_rl   = rdload_cyc;
        @(negedge clk);
        start  = 1'b1;
        length = 10'(len);
        mode   = 2'(md);
        seed   = sd;
        @(negedge clk);
        start  = 1'b0;
        length = 10'($urandom);
        mode   = 2'($urandom);
        seed   = 16'($urandom);
        if (!sdram_init_done) begin
            repeat (10) @(negedge clk);
            check({name, " wait_init busy"},    32'(busy),    1);
            check({name, " wait_init wr_load"}, 32'(wr_load), 1);
            check({name, " wait_init rd_load"}, 32'(rd_load), 1);
            check({name, " wait_init sys_we"},  32'(sys_we),  0);
            sdram_init_done = 1'b1;
        end
        wait_done(3 * len + 300, ok);
        check({name, " done seen"}, 32'(ok), 1);
        @(negedge clk);
        check({name, " done one cycle"}, 32'(done), 0);

        exp_err   = 0;
        exp_first = 0;
        for (int i = 0; i < len; i++) begin
            if (corrupt[i]) begin
                if (exp_err == 0) exp_first = i;
                exp_err++;
            end
        end

        n_we = wr_log.size() - b_we;
        check({name, " write beats"}, n_we, len);
        for (int i = 0; i < len && i < n_we; i++) begin
            check($sformatf("%s wdata[%0d]", name, i), 32'(wr_log[b_we + i]), 32'(exp_pat(md, sd, i)));
        end
        check({name, " read beats"},    rd_beats - b_rd,     len);
        check({name, " done pulses"},   done_cnt - b_done,   1);
        check({name, " rd_load cycles"}, rdload_cyc - b_rl,  LOAD_CYC);
        check({name, " err_cnt"},       32'(err_cnt),        exp_err);
        check({name, " first_err_idx"}, 32'(first_err_idx), exp_first);
        check({name, " pass"},          32'(pass),           (exp_err == 0) ? 1 : 0);
        check({name, " init_lost"},     32'(init_lost),      0);
        check({name, " busy after"},    32'(busy),           0);
    endtask

    initial begin
        rst_n           = 1'b0;
        start           = 1'b0;
        length          = '0;
        mode            = '0;
        seed            = '0;
        sdram_init_done = 1'b0;
        clear_corrupt();
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Incrementing pattern, 512 words, with a WAIT_INIT hold at the front
        run_test("mode0_len512", 512, 0, 16'h0000);

        // Walking one wraps after sixteen words
        run_test("walk_len20", 20, 2, 16'($urandom));

        // Two corrupted read words
        clear_corrupt();
        corrupt[37]  = 1'b1;
        corrupt[100] = 1'b1;
        run_test("corrupt_37_100", 128, 3, 16'($urandom));
        clear_corrupt();

        // sdram_init_done lost in the middle of the write burst
        base_we   = wr_log.size();
        base_done = done_cnt;
        @(negedge clk);
        start  = 1'b1;
        length = 10'd50;
        mode   = 2'd0;
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (sys_we && sys_data_in == 16'd10) begin
                got = 1'b1;
                break;
            end
        end
        check("drop reach idx10", 32'(got), 1);
        sdram_init_done = 1'b0;
        @(negedge clk);
        check("drop sys_we low", 32'(sys_we), 0);
        wait_done(100, got);
        check("drop done seen", 32'(got), 1);
        @(negedge clk);
        check("drop write beats", wr_log.size() - base_we, 11);
        check("drop done pulses", done_cnt - base_done, 1);
        check("drop init_lost", 32'(init_lost), 1);
        check("drop pass", 32'(pass), 0);
        check("drop busy", 32'(busy), 0);
        sdram_init_done = 1'b1;
        repeat (2) @(negedge clk);

        // Randomized runs with random corruption
        for (int r = 0; r < 3; r++) begin
            int len;
            len = int'($urandom_range(1, 300));
            clear_corrupt();
            for (int k = 0; k < int'($urandom_range(0, 3)); k++) begin
                corrupt[$urandom_range(0, len - 1)] = 1'b1;
            end
            run_test($sformatf("rand%0d", r), len, int'($urandom_range(0, 3)), 16'($urandom));
        end
        clear_corrupt();

        // Longest run: index must reach 1022 without wrapping
        run_test("len1023", 1023, 1, 16'h0000);

        // Second start while busy is ignored; reset mid-READ aborts quietly
        base_we   = wr_log.size();
        base_done = done_cnt;
        @(negedge clk);
        start  = 1'b1;
        length = 10'd100;
        mode   = 2'd1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        start  = 1'b1;
        length = 10'd5;
        mode   = 2'd0;
        @(negedge clk);
        start = 1'b0;
        got   = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (sys_rd) begin
                got = 1'b1;
                break;
            end
        end
        check("rst reach READ", 32'(got), 1);
        repeat (5) @(negedge clk);
        check("second start ignored", wr_log.size() - base_we, 100);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_vals("mid_read_reset");
        rst_n = 1'b1;
        seen  = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done) seen++;
        end
        check("no done after reset", seen, 0);
        check("no done pulses counted", done_cnt - base_done, 0);

        // Zero-length run still performs the load phases and passes
        run_test("len0", 0, 0, 16'h0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sdram_bist_ctrl.md
SDRAM_BIST_CTRL -- requirements
Module: sdram_bist_ctrl

Interface
Parameters:
REQ-001 The block SHALL have parameter DATA_W, default 16, meaning width of the FIFO data words.
REQ-002 The block SHALL have parameter LOAD_CYC, default 4, meaning cycles that wr_load/rd_load are held high per address reset.
REQ-003 The block SHALL have parameter FILL_WAIT, default 64, meaning cycles waited between end of write and first sys_rd, to allow the read FIFO to fill.
REQ-004 The block SHALL have parameter RD_LAT, default 1, meaning cycles from sys_rd high to valid sys_data_out.

Ports:
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock, which also drives the FIFO user side. All logic is on the rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 The block SHALL have port start, input, 1 bit: a one-cycle pulse that launches a test run.
REQ-008 The block SHALL have port length, input, 10 bits: number of words to write and read, sampled on start.
REQ-009 The block SHALL have port mode, input, 2 bits: pattern select, sampled on start.
REQ-010 The block SHALL have port seed, input, DATA_W bits: pattern seed, sampled on start.
REQ-011 The block SHALL have port sdram_init_done, input, 1 bit: SDRAM initialisation complete.
REQ-012 The block SHALL have ports wr_load and rd_load, output, 1 bit each: SDRAM write/read address reset.
REQ-013 The block SHALL have ports sys_we, output, 1 bit, and sys_data_in, output, DATA_W bits: write-FIFO interface.
REQ-014 The block SHALL have ports sys_rd, output, 1 bit, and sys_data_out, input, DATA_W bits: read-FIFO interface.
REQ-015 The block SHALL have output busy, 1 bit: a run is in progress.
REQ-016 The block SHALL have output done, 1 bit: a one-cycle pulse at the end of a run.
REQ-017 The block SHALL have output pass, 1 bit: the result of the last run.
REQ-018 The block SHALL have output init_lost, 1 bit: the last run was aborted because sdram_init_done fell.
REQ-019 The block SHALL have output err_cnt, 16 bits: saturating mismatch count.
REQ-020 The block SHALL have output first_err_idx, 10 bits: word index of the first mismatch.

Function
REQ-021 The state machine SHALL have states IDLE, WAIT_INIT, LOAD_WR, WRITE, LOAD_RD, FILL, READ, DRAIN, FINISH.
REQ-022 In IDLE, start SHALL latch length, mode and seed, clear err_cnt, first_err_idx and init_lost, and go to WAIT_INIT; start in any other state SHALL be ignored.
REQ-023 In WAIT_INIT, the block SHALL hold wr_load=1 and rd_load=1 until sdram_init_done=1, then go to LOAD_WR.
REQ-024 In LOAD_WR, the block SHALL hold wr_load=1 for LOAD_CYC cycles, then drop it and enter WRITE.
REQ-025 In WRITE, the block SHALL drive sys_we=1 for exactly length consecutive cycles, with sys_data_in = pattern(index), index running 0..length-1.
REQ-026 After WRITE, LOAD_RD SHALL hold rd_load=1 for LOAD_CYC cycles, and FILL SHALL then wait FILL_WAIT cycles.
REQ-027 In READ, the block SHALL drive sys_rd=1 for exactly length consecutive cycles.
REQ-028 Each sys_data_out word SHALL be compared with pattern(index) RD_LAT cycles after its sys_rd, using a delayed index/valid pipeline.
REQ-029 DRAIN SHALL last RD_LAT cycles so that the last word is compared.
REQ-030 On a mismatch, err_cnt SHALL increment, saturating at 16'hFFFF.
REQ-031 first_err_idx SHALL be captured only on the first mismatch of a run.
REQ-032 The patterns SHALL be:
- mode 0 = index (zero-extended)
- mode 1 = ~index
- mode 2 = 1 << index[3:0] (walking one)
- mode 3 = seed XOR index
REQ-033 In FINISH, the block SHALL pulse done for one cycle, set pass = (err_cnt==0 && !init_lost), and return to IDLE.
REQ-034 busy SHALL be 1 in every state except IDLE.
REQ-035 length=0 SHALL skip WRITE/READ activity (no sys_we/sys_rd), still perform the load phases, and finish with pass=1.
REQ-036 If sdram_init_done falls in any state from LOAD_WR to DRAIN, the block SHALL drop sys_we/sys_rd the next cycle, set init_lost=1, and go to FINISH (pass=0).
REQ-037 The index counter SHALL be 10-bit; length=1023 SHALL produce 1023 words with no wrap.

Reset
REQ-038 While rst_n=0 at a clock edge, the block SHALL reset state=IDLE and all outputs: wr_load=1, rd_load=1, sys_we=0, sys_rd=0, sys_data_in=0, busy=0, done=0, pass=0, init_lost=0, err_cnt=0, first_err_idx=0.
REQ-039 Reset asserted mid-run SHALL abort without a done pulse.

Structure
REQ-040 Package sdram_bist_pkg SHALL hold the state encoding, the mode codes and the err_cnt saturation constant.
REQ-041 Sub-module sdram_bist_patgen SHALL compute pattern(mode, seed, index) and SHALL be instanced twice: write side and compare side.

Verification
REQ-042 Bench with an ideal FIFO model (RD_LAT=1): mode 0, length=512 -> 512 sys_we beats carrying 0..511, 512 sys_rd beats, done, pass=1, err_cnt=0.
REQ-043 Mode 2 with length=20 -> sys_data_in sequence 0x0001..0x8000, then 0x0001..0x0008; pass=1.
REQ-044 Model corrupts word 37 and word 100 -> err_cnt=2, first_err_idx=37, pass=0.
REQ-045 sdram_init_done dropped during WRITE at index 10 -> sys_we low next cycle, init_lost=1, done pulse, pass=0.
REQ-046 start repeated while busy, then rst_n=0 during READ -> second start ignored; after reset all outputs at reset values, no done pulse; a fresh run with length=0 gives pass=1 with no sys_we/sys_rd.
